// File: rtl/axi_rd_responder.sv
// AXI4 read responder (AR + R) over a word-addressed memory array.
// One burst at a time, FIXED/INCR/WRAP, with a backdoor load port.
module axi_rd_responder #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_index,
  input  logic [DATA_WIDTH-1:0]        ld_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [7:0]            cnt_q;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [ADDR_WIDTH-1:0] ar_step;
  logic                  wrap_len_ok;
  logic                  ar_err;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic                  src_err;
  logic [ADDR_WIDTH-1:0] off;
  logic                  oob;
  logic                  beat_bad;
  logic [DATA_WIDTH-1:0] beat_data;

  // address of the next beat of the latched burst
  always_comb begin
    step     = ADDR_WIDTH'(1) << size_q;
    wmask    = (step * (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)))
             - ADDR_WIDTH'(1);
    nxt_addr = addr_q;
    unique case (1'b1)
      burst_q == 2'b01:
        nxt_addr = addr_q + step;
      burst_q == 2'b10:
        nxt_addr = (addr_q & ~wmask)
                 | ((addr_q + step) & wmask);
      default:
        nxt_addr = addr_q;
    endcase
  end

  // burst-wide error from the incoming AR request
  always_comb begin
    ar_step     = ADDR_WIDTH'(1) << s_axi_arsize;
    wrap_len_ok = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3)
               || (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);
    ar_err      = (s_axi_arsize > 3'd3)
               || (s_axi_arburst == 2'b11)
               || ((s_axi_arburst == 2'b10)
                   && (!wrap_len_ok
                       || ((s_axi_araddr & (ar_step - ADDR_WIDTH'(1)))
                           != '0)));
  end

  // single read port: beat 0 from AR, later beats from nxt_addr
  always_comb begin
    src_addr  = (state_q == BURST) ? nxt_addr : s_axi_araddr;
    src_err   = (state_q == BURST) ? err_q : ar_err;
    off       = src_addr - BASE_ADDR;
    oob       = (src_addr < BASE_ADDR)
             || ((off >> 3) >= ADDR_WIDTH'(MEM_WORDS));
    beat_bad  = src_err || oob;
    beat_data = '0;
    if (!beat_bad) begin
      beat_data = mem[off[IDX_W+2:3]];
    end
  end

  // backdoor preload; a beat read on the same edge sees the old word
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_index] <= ld_data;
    end
  end

  assign s_axi_arready = (state_q == IDLE) && reset;

  // burst FSM with registered R outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      s_axi_rid    <= '0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= '0;
      s_axi_rlast  <= 1'b0;
      s_axi_rvalid <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_axi_arvalid) begin
            state_q      <= BURST;
            addr_q       <= s_axi_araddr;
            len_q        <= s_axi_arlen;
            size_q       <= s_axi_arsize;
            burst_q      <= s_axi_arburst;
            err_q        <= ar_err;
            cnt_q        <= '0;
            s_axi_rid    <= s_axi_arid;
            s_axi_rdata  <= beat_data;
            s_axi_rresp  <= beat_bad ? 2'b10 : 2'b00;
            s_axi_rlast  <= (s_axi_arlen == 8'd0);
            s_axi_rvalid <= 1'b1;
          end
        end
        BURST: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              state_q      <= IDLE;
              s_axi_rvalid <= 1'b0;
              s_axi_rlast  <= 1'b0;
            end else begin
              addr_q      <= nxt_addr;
              cnt_q       <= cnt_q + 8'd1;
              s_axi_rdata <= beat_data;
              s_axi_rresp <= beat_bad ? 2'b10 : 2'b00;
              s_axi_rlast <= ((cnt_q + 8'd1) == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
